// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the mic-to-histogram frame sequencer.
package fft_seq_pkg;

  typedef enum logic [2:0] {FILL, LOAD, START, WAIT, PUBLISH} state_t;

  localparam int N_POINTS_DEF = 16;
  localparam int IDX_W        = $clog2(N_POINTS_DEF);

  // Right-shift a magnitude and clamp it to the largest bin_w-bit value.
  function automatic logic [31:0] sat_scale(input logic [31:0] mag, input int shift,
                                            input int bin_w);
    logic [31:0] s;
    logic [31:0] lim;
    s   = mag >> shift;
    lim = (32'd1 << bin_w) - 32'd1;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame sample store: one write port for capture, one combinational read port for streaming.
module fft_frame_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: capture mic samples, feed the FFT engine, collect scaled magnitudes,
// and hand the finished histogram to the display side.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int SAMPLE_W = 16,
  parameter int DATA_W   = 32,
  parameter int MAG_W    = 18,
  parameter int SHIFT    = 8,
  parameter int BIN_W    = 10,
  parameter int TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mic_valid,
  input  logic [SAMPLE_W-1:0]         mic_sample,
  output logic                        fft_ld_valid,
  output logic [$clog2(N_POINTS)-1:0] fft_ld_idx,
  output logic [DATA_W-1:0]           fft_ld_data,
  output logic                        fft_start,
  input  logic                        fft_done,
  input  logic                        fft_mag_valid,
  input  logic [$clog2(N_POINTS)-1:0] fft_mag_idx,
  input  logic [MAG_W-1:0]            fft_mag,
  output logic                        hist_valid,
  input  logic                        hist_ready,
  output logic [N_POINTS*BIN_W-1:0]   hist_bins,
  output logic [15:0]                 drop_cnt,
  output logic                        err_timeout
);

  localparam int AW   = $clog2(N_POINTS);
  localparam int TO_W = $clog2(TIMEOUT);

  state_t              state, state_nxt;
  logic [AW-1:0]       wr_ptr, ld_idx;
  logic [TO_W-1:0]     tcnt;
  logic [N_POINTS-1:0] mask, mask_nxt;
  logic                done_seen, done_nxt;
  logic                publish;
  logic [BIN_W-1:0]    shadow [N_POINTS];
  logic [BIN_W-1:0]    mag_bin;
  logic [SAMPLE_W-1:0] rd_sample;
  logic                buf_we;

  assign buf_we  = (state == FILL) && mic_valid;
  assign mag_bin = BIN_W'(sat_scale(32'(fft_mag), SHIFT, BIN_W));

  fft_frame_buf #(.DEPTH(N_POINTS), .W(SAMPLE_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (mic_sample),
    .raddr (ld_idx),
    .rdata (rd_sample)
  );

  assign fft_ld_idx  = fft_ld_valid ? ld_idx : '0;
  assign fft_ld_data = fft_ld_valid ? DATA_W'(signed'(rd_sample)) : '0;

  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask;
    done_nxt     = done_seen;
    publish      = 1'b0;
    fft_ld_valid = 1'b0;
    fft_start    = 1'b0;
    hist_valid   = 1'b0;
    err_timeout  = 1'b0;
    case (state)
      FILL:  if (mic_valid && wr_ptr == AW'(N_POINTS-1)) state_nxt = LOAD;
      LOAD: begin
        fft_ld_valid = 1'b1;
        if (ld_idx == AW'(N_POINTS-1)) state_nxt = START;
      end
      START: begin
        fft_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Look at this cycle's magnitude and done so publishing costs no extra cycle.
        if (fft_mag_valid) mask_nxt = mask | (N_POINTS'(1) << fft_mag_idx);
        done_nxt = done_seen | fft_done;
        if (done_nxt && (&mask_nxt)) begin
          publish   = 1'b1;
          state_nxt = PUBLISH;
        end else if (tcnt == TO_W'(TIMEOUT-1)) begin
          err_timeout = 1'b1;
          state_nxt   = FILL;
        end
      end
      PUBLISH: begin
        hist_valid = 1'b1;
        if (hist_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      ld_idx    <= '0;
      tcnt      <= '0;
      mask      <= '0;
      done_seen <= 1'b0;
      hist_bins <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      done_seen <= done_nxt;
      if (buf_we) wr_ptr <= wr_ptr + 1'b1;
      if (state == LOAD) ld_idx <= ld_idx + 1'b1;
      if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (state == START) begin
        tcnt      <= '0;
        mask      <= '0;
        done_seen <= 1'b0;
      end
      if (publish) begin
        for (int k = 0; k < N_POINTS; k++)
          hist_bins[k*BIN_W +: BIN_W] <= (fft_mag_valid && fft_mag_idx == AW'(k)) ? mag_bin
                                                                                   : shadow[k];
      end
      if (mic_valid && state != FILL && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Bins are only published once every index has been written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == WAIT && fft_mag_valid) shadow[fft_mag_idx] <= mag_bin;
  end

endmodule
